// File: rtl/alu_issue_ctrl.sv
// Three-cycle issue controller (IDLE -> EXEC -> WB) for a 16-bit ALU with an 8 x 16 register file and C/Z flags.
// Optional build macro ALU_ISSUE_R0_ZERO_EN makes R0 a hard-wired zero register.
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [1:0]  ALUcontrol,
  output logic [15:0] DataA,
  output logic [15:0] DataB,
  input  logic [15:0] Result,
  input  logic        Zero,
  input  logic        Carry,
  output logic        wb_en,
  output logic [2:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        err,
  output logic        flag_c,
  output logic        flag_z,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_valid while instr_ready is 0 is ignored.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [1:0]  alu_ctl_q, alu_ctl_d;
  logic [15:0] data_a_q, data_a_d;
  logic [15:0] data_b_q, data_b_d;
  logic [2:0]  rc_q, rc_d;
  logic        do_wb_q, do_wb_d;
  logic        illegal_q, illegal_d;
  logic        is_add_q, is_add_d;
  logic        wb_en_q, wb_en_d;
  logic [2:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        flag_c_q, flag_c_d;
  logic        flag_z_q, flag_z_d;
  logic [15:0] rf_q [8];
  logic [15:0] rf_d [8];

  logic [3:0]  opcode;
  logic [2:0]  ra, rb, rc;
  logic [1:0]  cond;
  logic        op_legal, cond_legal, cond_ok;
  logic [1:0]  op_ctl;
  logic [15:0] rd_a, rd_b, rd_dbg;
  logic        unused_bits;

  assign opcode      = instr[15:12];
  assign ra          = instr[11:9];
  assign rb          = instr[8:6];
  assign rc          = instr[5:3];
  assign cond        = instr[1:0];
  assign unused_bits = instr[2];

`ifdef ALU_ISSUE_R0_ZERO_EN
  assign rd_a   = (ra == 3'd0) ? 16'h0000 : rf_q[ra];
  assign rd_b   = (rb == 3'd0) ? 16'h0000 : rf_q[rb];
  assign rd_dbg = (dbg_addr == 3'd0) ? 16'h0000 : rf_q[dbg_addr];
`else
  assign rd_a   = rf_q[ra];
  assign rd_b   = rf_q[rb];
  assign rd_dbg = rf_q[dbg_addr];
`endif

  always_comb begin
    op_legal = 1'b1;
    op_ctl   = 2'b11;
    case (opcode)
      4'b0000: op_ctl = 2'b00;
      4'b0010: op_ctl = 2'b01;
      4'b0011: op_ctl = 2'b10;
      default: op_legal = 1'b0;
    endcase
    cond_legal = (cond != 2'b11);
    // Condition looks at the flags as they stand when the instruction is accepted.
    case (cond)
      2'b00:   cond_ok = 1'b1;
      2'b10:   cond_ok = flag_c_q;
      2'b01:   cond_ok = flag_z_q;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b0;
    alu_ctl_d = 2'b11;
    data_a_d  = 16'h0000;
    data_b_d  = 16'h0000;
    rc_d      = rc_q;
    do_wb_d   = do_wb_q;
    illegal_d = illegal_q;
    is_add_d  = is_add_q;
    wb_en_d   = 1'b0;
    wb_addr_d = 3'd0;
    wb_data_d = 16'h0000;
    err_d     = 1'b0;
    zero_d    = zero_q;
    carry_d   = carry_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    rf_d      = rf_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          state_d   = S_EXEC;
          alu_ctl_d = (op_legal && cond_legal) ? op_ctl : 2'b11;
          data_a_d  = rd_a;
          data_b_d  = rd_b;
          rc_d      = rc;
          do_wb_d   = op_legal && cond_legal && cond_ok;
          illegal_d = !(op_legal && cond_legal);
          is_add_d  = (opcode == 4'b0000);
        end else begin
          ready_d = 1'b1;
        end
      end
      S_EXEC: begin
        state_d   = S_WB;
        wb_en_d   = do_wb_q;
        err_d     = illegal_q;
        wb_addr_d = rc_q;
        wb_data_d = Result;
        zero_d    = Zero;
        carry_d   = Carry;
      end
      S_WB: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        if (wb_en_q) begin
`ifdef ALU_ISSUE_R0_ZERO_EN
          if (wb_addr_q != 3'd0) rf_d[wb_addr_q] = wb_data_q;
`else
          rf_d[wb_addr_q] = wb_data_q;
`endif
          flag_z_d = zero_q;
          if (is_add_q) flag_c_d = carry_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      alu_ctl_q <= 2'b11;
      data_a_q  <= 16'h0000;
      data_b_q  <= 16'h0000;
      rc_q      <= 3'd0;
      do_wb_q   <= 1'b0;
      illegal_q <= 1'b0;
      is_add_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= 3'd0;
      wb_data_q <= 16'h0000;
      err_q     <= 1'b0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      alu_ctl_q <= alu_ctl_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      rc_q      <= rc_d;
      do_wb_q   <= do_wb_d;
      illegal_q <= illegal_d;
      is_add_q  <= is_add_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      rf_q      <= rf_d;
    end
  end

  assign instr_ready = ready_q;
  assign ALUcontrol  = alu_ctl_q;
  assign DataA       = data_a_q;
  assign DataB       = data_b_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign err         = err_q;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign dbg_data    = rd_dbg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, reference register/flag model, write-back scoreboard.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [1:0]  ALUcontrol;
  logic [15:0] DataA, DataB;
  logic [15:0] Result;
  logic        Zero, Carry;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        err;
  logic        flag_c, flag_z;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

`ifdef ALU_ISSUE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [20:0] exp_q[$];
  logic [15:0] m_rf [8];
  logic        m_c, m_z;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ALUcontrol(ALUcontrol), .DataA(DataA), .DataB(DataB),
    .Result(Result), .Zero(Zero), .Carry(Carry), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .err(err), .flag_c(flag_c), .flag_z(flag_z),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always_comb begin
    Result = 16'h0000;
    Carry  = 1'b0;
    case (ALUcontrol)
      2'b00:   {Carry, Result} = {1'b0, DataA} + {1'b0, DataB};
      2'b01:   Result = ~(DataA & DataB);
      2'b10:   {Carry, Result} = {1'b0, DataA} - {1'b0, DataB};
      default: Result = 16'h0000;
    endcase
    Zero = (Result == 16'h0000);
  end

  function automatic logic [16:0] ref_alu(input logic [1:0] ctl, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] cr;
    case (ctl)
      2'b00:   cr = {1'b0, a} + {1'b0, b};
      2'b01:   cr = {1'b0, ~(a & b)};
      2'b10:   cr = {1'b0, a} - {1'b0, b};
      default: cr = 17'h0;
    endcase
    return cr;
  endfunction

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [2:0] rc, input logic [1:0] cnd);
    return {op, ra, rb, rc, 1'b0, cnd};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    logic [3:0] op;
    logic [2:0] ra, rb, rc;
    logic [1:0] cnd, ctl;
    logic legal, cond_ok, do_wb;
    logic [15:0] a, b;
    logic [16:0] cr;
    logic [20:0] e;
    int waited;
    op = ins[15:12]; ra = ins[11:9]; rb = ins[8:6]; rc = ins[5:3]; cnd = ins[1:0];
    legal = (op == 4'b0000 || op == 4'b0010 || op == 4'b0011) && (cnd != 2'b11);
    ctl = (op == 4'b0000) ? 2'b00 : (op == 4'b0010) ? 2'b01 : 2'b10;
    waited = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: instr_ready=%b after %0d cycles, required 1", instr_ready, waited);
      return;
    end
    cond_ok = (cnd == 2'b00) || (cnd == 2'b10 && m_c) || (cnd == 2'b01 && m_z);
    do_wb = legal && cond_ok;
    a = m_rf[ra];
    b = m_rf[rb];
    cr = ref_alu(ctl, a, b);
    exp_q.push_back({do_wb, !legal, rc, cr[15:0]});
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'($urandom_range(0, 1));
    instr = 16'($urandom);
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b0 || wb_en !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL exec_ctrl: ready=%b wb_en=%b err=%b, required 0 0 0", instr_ready, wb_en, err);
    end
    if (legal) begin
      checks++;
      if ({ALUcontrol, DataA, DataB} !== {ctl, a, b}) begin
        errors++;
        $display("FAIL exec_ops: ctl=%b A=%h B=%h, required %b %h %h", ALUcontrol, DataA, DataB, ctl, a, b);
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({wb_en, err} !== e[20:19]) begin
      errors++;
      $display("FAIL wb_strobe: wb_en=%b err=%b, required %b %b", wb_en, err, e[20], e[19]);
    end
    if (e[20]) begin
      checks++;
      if ({wb_addr, wb_data} !== e[18:0]) begin
        errors++;
        $display("FAIL wb_payload: addr=%0d data=%h, required %0d %h", wb_addr, wb_data, e[18:16], e[15:0]);
      end
    end
    checks++;
    if (ALUcontrol !== 2'b11 || DataA !== 16'h0 || DataB !== 16'h0) begin
      errors++;
      $display("FAIL idle_ops: ctl=%b A=%h B=%h, required 11 0000 0000", ALUcontrol, DataA, DataB);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    if (do_wb) begin
      if (!(R0Z && rc == 3'd0)) m_rf[rc] = cr[15:0];
      m_z = (cr[15:0] == 16'h0000);
      if (ctl == 2'b00) m_c = cr[16];
    end
    dbg_addr = rc;
    #1;
    checks++;
    if ({instr_ready, flag_c, flag_z, dbg_data} !== {1'b1, m_c, m_z, m_rf[rc]}) begin
      errors++;
      $display("FAIL post_wb: ready=%b c=%b z=%b R%0d=%h, required 1 %b %b %h",
               instr_ready, flag_c, flag_z, rc, dbg_data, m_c, m_z, m_rf[rc]);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic test_reset();
    logic bad;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 3'd0;
    model_reset();
    #12;
    check_val("reset_outputs", {22'h0, instr_ready, wb_en, err, flag_c, flag_z, ALUcontrol, 3'b0},
              {22'h0, 5'b00000, 2'b11, 3'b0});
    check_val("reset_operands", {DataA, DataB}, 32'h0);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      if (dbg_data !== 16'h0) bad = 1'b1;
    end
    check_val("reset_regs", {31'h0, bad}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("ready_low_after_release_edge", {31'h0, instr_ready}, 32'h0);
    @(posedge clk); #1;
    check_val("ready_rise_after_reset", {31'h0, instr_ready}, 32'h1);
  endtask

  task automatic test_setup_and_add();
    issue(mk(4'b0010, 3'd0, 3'd0, 3'd7, 2'b00));
    issue(mk(4'b0011, 3'd0, 3'd7, 3'd6, 2'b00));
    issue(mk(4'b0000, 3'd6, 3'd6, 3'd2, 2'b00));
    issue(mk(4'b0000, 3'd2, 3'd6, 3'd1, 2'b00));
    issue(mk(4'b0000, 3'd1, 3'd2, 3'd1, 2'b00));
    issue(mk(4'b0000, 3'd2, 3'd6, 3'd2, 2'b00));
    issue(mk(4'b0000, 3'd1, 3'd2, 3'd3, 2'b00));
    dbg_addr = 3'd3; #1;
    check_val("add_5_plus_3", {14'h0, flag_c, flag_z, dbg_data}, 32'h0000_0008);
  endtask

  task automatic test_r0();
    issue(mk(4'b0000, 3'd6, 3'd6, 3'd4, 2'b00));
    issue(mk(4'b0000, 3'd4, 3'd2, 3'd0, 2'b00));
    dbg_addr = 3'd0; #1;
    check_val("r0_write", {16'h0, dbg_data}, R0Z ? 32'h0 : 32'h5);
  endtask

  task automatic test_carry_sub();
    issue(mk(4'b0000, 3'd2, 3'd6, 3'd5, 2'b00));
    issue(mk(4'b0000, 3'd7, 3'd6, 3'd4, 2'b00));
    check_val("add_carry_flags", {30'h0, flag_c, flag_z}, 32'h3);
    issue(mk(4'b0011, 3'd5, 3'd5, 3'd4, 2'b00));
    check_val("sub_keeps_carry", {30'h0, flag_c, flag_z}, 32'h3);
  endtask

  task automatic test_cond();
    issue(mk(4'b0000, 3'd6, 3'd6, 3'd4, 2'b00));
    issue(mk(4'b0000, 3'd1, 3'd2, 3'd3, 2'b10));
    issue(mk(4'b0000, 3'd1, 3'd6, 3'd3, 2'b01));
    dbg_addr = 3'd3; #1;
    check_val("cond_skip_keeps_reg", {16'h0, dbg_data}, 32'h8);
    issue(mk(4'b0011, 3'd6, 3'd6, 3'd4, 2'b00));
    issue(mk(4'b0000, 3'd1, 3'd6, 3'd3, 2'b01));
    dbg_addr = 3'd3; #1;
    check_val("cond_z_taken", {16'h0, dbg_data}, 32'h6);
  endtask

  task automatic test_nand_illegal();
    issue(mk(4'b0000, 3'd7, 3'd6, 3'd4, 2'b00));
    issue(mk(4'b0000, 3'd6, 3'd6, 3'd4, 2'b00));
    issue(mk(4'b0010, 3'd7, 3'd7, 3'd4, 2'b00));
    check_val("nand_flags", {30'h0, flag_c, flag_z}, 32'h1);
    issue(mk(4'b0111, 3'd1, 3'd2, 3'd5, 2'b00));
    issue(mk(4'b0000, 3'd1, 3'd2, 3'd5, 2'b11));
    dbg_addr = 3'd5; #1;
    check_val("illegal_no_write", {16'h0, dbg_data}, 32'h4);
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [1:0] cnd;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: op = 4'b0000;
        3, 4:    op = 4'b0010;
        5, 6:    op = 4'b0011;
        default: op = 4'($urandom_range(4, 15));
      endcase
      cnd = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(0, 3));
      issue(mk(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), cnd));
    end
  endtask

  task automatic test_rst_exec();
    logic bad;
    int waited;
    waited = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    instr = mk(4'b0010, 3'd0, 3'd0, 3'd5, 2'b00);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check_val("rst_exec_outputs", {26'h0, instr_ready, wb_en, err, ALUcontrol, 1'b0}, {26'h0, 3'b000, 2'b11, 1'b0});
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      if (dbg_data !== 16'h0) bad = 1'b1;
    end
    check_val("rst_exec_regs", {29'h0, bad, flag_c, flag_z}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_rst_exec", {31'h0, instr_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wb_en !== 1'b0 || err !== 1'b0) bad = 1'b1;
    end
    check_val("rst_exec_no_wb", {31'h0, bad}, 32'h0);
    issue(mk(4'b0010, 3'd0, 3'd0, 3'd5, 2'b00));
  endtask

  initial begin
    test_reset();
    test_setup_and_add();
    test_r0();
    test_carry_sub();
    test_cond();
    test_nand_illegal();
    test_back_to_back();
    test_rst_exec();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: instr_valid  in  1  instruction offered; instr  in  16  instruction word.
REQ-004 SHALL have: instr_ready  out  1  block accepts instruction this cycle.
REQ-005 SHALL have: ALUcontrol  out  2  op to ALU (00 add, 01 nand, 10 sub, 11 idle); DataA, DataB  out  16  ALU operands.
REQ-006 SHALL have: Result  in  16, Zero  in  1, Carry  in  1  combinational ALU response.
REQ-007 SHALL have: wb_en  out  1, wb_addr  out  3, wb_data  out  16  register write-back strobe; err  out  1  illegal-op pulse.
REQ-008 SHALL have: flag_c, flag_z  out  1  architectural flags; dbg_addr  in  3, dbg_data  out  16  combinational register read.

Function
REQ-009 SHALL contain an 8 x 16-bit register file R0-R7.
REQ-010 Instr format SHALL be: [15:12] opcode, [11:9] RA, [8:6] RB, [5:3] RC, [2] ignored, [1:0] cond.
REQ-011 Opcodes SHALL be: 0000 ADD, 0010 NAND, 0011 SUB; all others illegal.
REQ-012 cond SHALL be: 00 always, 10 execute only if flag_c=1, 01 execute only if flag_z=1, 11 illegal.
REQ-013 FSM states SHALL be IDLE, EXEC, WB; instr_ready=1 only in IDLE and not in reset.
REQ-014 Handshake: instr_valid & instr_ready at edge T latches instr, R[RA], R[RB] into operand registers; IDLE->EXEC.
REQ-015 In EXEC (cycle T+1) ALUcontrol, DataA=R[RA], DataB=R[RB] SHALL be driven from registers; Result/Zero/Carry captured at end of cycle; EXEC->WB.
REQ-016 In WB (cycle T+2) wb_en SHALL pulse one cycle with wb_addr=RC, wb_data=captured Result, R[RC] written at end of cycle; WB->IDLE.
REQ-017 Throughput SHALL be one instruction per 3 cycles; latency accept-to-write 2 cycles.
REQ-018 Outside EXEC, ALUcontrol SHALL be 11 and DataA/DataB SHALL be 0.
REQ-019 ADD SHALL update flag_c and flag_z; NAND and SUB SHALL update flag_z only; flags update at end of WB.
REQ-020 Condition SHALL be evaluated on flags at acceptance; failed condition: ALU still sequenced, wb_en=0, flags unchanged.
REQ-021 Illegal opcode or cond=11: err pulses 1 cycle in WB, no write, flags unchanged, FSM still returns to IDLE.
REQ-022 RC equal to RA or RB SHALL be legal; operands use pre-write values.
REQ-023 instr_valid while not ready SHALL be ignored; instr held or changed by source has no effect.
REQ-024 dbg_data SHALL reflect R[dbg_addr] including a write at the preceding edge.

Reset
REQ-025 rst=1 SHALL immediately force: state IDLE, R0-R7=0, flag_c=flag_z=0, wb_en=0, err=0, instr_ready=0, ALUcontrol=11, DataA=DataB=0.
REQ-026 rst asserted in EXEC or WB SHALL abort the instruction with no write-back and no flag update.
REQ-027 instr_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-028 Macro ALU_ISSUE_R0_ZERO_EN defined: R0 SHALL read 0 always and writes to R0 SHALL be discarded (wb_en still pulses).
REQ-029 Macro undefined: R0 SHALL be an ordinary writable register.

Verification
REQ-030 Reset then ADD R1,R2->R3 with R1=0x0005,R2=0x0003 -> EXEC ALUcontrol=00; WB wb_en=1, wb_addr=3, wb_data=0x0008; flag_c=0, flag_z=0.
REQ-031 ADD 0xFFFF+0x0001 -> wb_data=0x0000, flag_c=1, flag_z=1; then SUB 0x0004-0x0004 -> flag_z=1, flag_c stays 1.
REQ-032 flag_c=0, ADD with cond=10 -> wb_en stays 0, R[RC] unchanged, flags unchanged, instr_ready back at T+3.
REQ-033 NAND 0xFFFF,0xFFFF -> wb_data=0x0000, flag_z=1, flag_c unchanged; opcode 0111 -> err=1 one cycle, no write.
REQ-034 rst pulsed during EXEC -> no wb_en, all registers 0, instr_ready=1 the cycle after release.
REQ-035 With ALU_ISSUE_R0_ZERO_EN: ADD 0x0002+0x0003 ->R0 -> dbg_addr=0 reads 0x0000; without macro reads 0x0005.
